hc_axil_reg_slice: RTL and testbench

//  Full-throughput AXI-Lite register slice on the holy core axi_lite_if signal set.

---
 rtl/hc_axil_reg_slice.sv | 146 ++++++++++++++
 tb/tb_hc_axil_reg_slice.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hc_axil_reg_slice.sv
// AXI-Lite register slice: one 2-entry skid buffer per channel so that valid,
// payload and ready on both sides come straight from flops.
// AW, W and AR flow s -> m; B and R flow m -> s.
module hc_axil_reg_slice #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // Core-side (slave) port
  input  logic [ADDR_WIDTH-1:0]   s_awaddr,
  input  logic                    s_awvalid,
  output logic                    s_awready,
  input  logic [DATA_WIDTH-1:0]   s_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_wstrb,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  output logic [1:0]              s_bresp,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  input  logic [ADDR_WIDTH-1:0]   s_araddr,
  input  logic                    s_arvalid,
  output logic                    s_arready,
  output logic [DATA_WIDTH-1:0]   s_rdata,
  output logic [1:0]              s_rresp,
  output logic                    s_rvalid,
  input  logic                    s_rready,
  // Bridge-side (master) port
  output logic [ADDR_WIDTH-1:0]   m_awaddr,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  input  logic [1:0]              m_bresp,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  output logic [ADDR_WIDTH-1:0]   m_araddr,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic [1:0]              m_rresp,
  input  logic                    m_rvalid,
  output logic                    m_rready
);

  localparam int unsigned StrbWidth = DATA_WIDTH / 8;

  // Channel index: 0 = AW, 1 = W, 2 = B, 3 = AR, 4 = R
  for (genvar g = 0; g < 5; g++) begin : g_ch
    localparam int unsigned PW = (g == 1) ? DATA_WIDTH + StrbWidth :
                                 (g == 2) ? 2 :
                                 (g == 4) ? DATA_WIDTH + 2 : ADDR_WIDTH;

    logic          in_valid;
    logic          out_ready;
    logic [PW-1:0] in_payload;
    logic          in_hs;
    logic          out_hs;
    logic          out_valid_q, out_valid_d;
    logic          skid_valid_q, skid_valid_d;
    logic          in_ready_q;
    logic [PW-1:0] out_payload_q, out_payload_d;
    logic [PW-1:0] skid_payload_q, skid_payload_d;

    assign in_hs  = in_valid & in_ready_q;
    assign out_hs = out_valid_q & out_ready;

    // Next-state for main and skid registers
    always_comb begin
      out_valid_d    = out_valid_q;
      out_payload_d  = out_payload_q;
      skid_valid_d   = skid_valid_q;
      skid_payload_d = skid_payload_q;
      if (out_hs && skid_valid_q) begin
        // in_ready is low while skid is full, so no input beat competes here
        out_payload_d = skid_payload_q;
        skid_valid_d  = 1'b0;
      end else if (in_hs && (!out_valid_q || out_ready)) begin
        out_payload_d = in_payload;
        out_valid_d   = 1'b1;
      end else if (in_hs) begin
        skid_payload_d = in_payload;
        skid_valid_d   = 1'b1;
      end else if (out_hs) begin
        out_valid_d = 1'b0;
      end
    end

    // State registers; in_ready mirrors "skid empty" one cycle after reset release
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        out_valid_q    <= 1'b0;
        out_payload_q  <= '0;
        skid_valid_q   <= 1'b0;
        skid_payload_q <= '0;
        in_ready_q     <= 1'b0;
      end else begin
        out_valid_q    <= out_valid_d;
        out_payload_q  <= out_payload_d;
        skid_valid_q   <= skid_valid_d;
        skid_payload_q <= skid_payload_d;
        in_ready_q     <= ~skid_valid_d;
      end
    end

    if (g == 0) begin : g_aw
      assign in_valid   = s_awvalid;
      assign in_payload = s_awaddr;
      assign out_ready  = m_awready;
      assign s_awready  = in_ready_q;
      assign m_awvalid  = out_valid_q;
      assign m_awaddr   = out_payload_q;
    end else if (g == 1) begin : g_w
      assign in_valid            = s_wvalid;
      assign in_payload          = {s_wdata, s_wstrb};
      assign out_ready           = m_wready;
      assign s_wready            = in_ready_q;
      assign m_wvalid            = out_valid_q;
      assign {m_wdata, m_wstrb}  = out_payload_q;
    end else if (g == 2) begin : g_b
      assign in_valid   = m_bvalid;
      assign in_payload = m_bresp;
      assign out_ready  = s_bready;
      assign m_bready   = in_ready_q;
      assign s_bvalid   = out_valid_q;
      assign s_bresp    = out_payload_q;
    end else if (g == 3) begin : g_ar
      assign in_valid   = s_arvalid;
      assign in_payload = s_araddr;
      assign out_ready  = m_arready;
      assign s_arready  = in_ready_q;
      assign m_arvalid  = out_valid_q;
      assign m_araddr   = out_payload_q;
    end else begin : g_r
      assign in_valid            = m_rvalid;
      assign in_payload          = {m_rdata, m_rresp};
      assign out_ready           = s_rready;
      assign m_rready            = in_ready_q;
      assign s_rvalid            = out_valid_q;
      assign {s_rdata, s_rresp}  = out_payload_q;
    end
  end

endmodule

// File: tb/tb_hc_axil_reg_slice.sv
// Bench for hc_axil_reg_slice: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a per-channel FIFO model
// (a channel holds up to two beats; out side shows the oldest, in side ready below two).
module tb_hc_axil_reg_slice;

  logic clk;
  logic rst_n;

  logic [31:0] s_awaddr, s_araddr, s_wdata, s_rdata, m_awaddr, m_araddr, m_wdata, m_rdata;
  logic [3:0]  s_wstrb, m_wstrb;
  logic [1:0]  s_bresp, s_rresp, m_bresp, m_rresp;
  logic s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic s_arvalid, s_arready, s_rvalid, s_rready;
  logic m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic m_arvalid, m_arready, m_rvalid, m_rready;

  // Channel view: 0 = AW, 1 = W, 2 = B, 3 = AR, 4 = R
  logic [63:0] in_pl [5];
  logic        in_v  [5];
  logic        out_r [5];
  logic [63:0] out_pl [5];
  logic        out_v  [5];
  logic        in_r   [5];
  logic        in_hs  [5];

  int total = 0;
  int bad   = 0;

  hc_axil_reg_slice #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  assign s_awaddr  = in_pl[0][31:0];
  assign s_awvalid = in_v[0];
  assign m_awready = out_r[0];
  assign out_pl[0] = {32'b0, m_awaddr};
  assign out_v[0]  = m_awvalid;
  assign in_r[0]   = s_awready;

  assign s_wdata   = in_pl[1][35:4];
  assign s_wstrb   = in_pl[1][3:0];
  assign s_wvalid  = in_v[1];
  assign m_wready  = out_r[1];
  assign out_pl[1] = {28'b0, m_wdata, m_wstrb};
  assign out_v[1]  = m_wvalid;
  assign in_r[1]   = s_wready;

  assign m_bresp   = in_pl[2][1:0];
  assign m_bvalid  = in_v[2];
  assign s_bready  = out_r[2];
  assign out_pl[2] = {62'b0, s_bresp};
  assign out_v[2]  = s_bvalid;
  assign in_r[2]   = m_bready;

  assign s_araddr  = in_pl[3][31:0];
  assign s_arvalid = in_v[3];
  assign m_arready = out_r[3];
  assign out_pl[3] = {32'b0, m_araddr};
  assign out_v[3]  = m_arvalid;
  assign in_r[3]   = s_arready;

  assign m_rdata   = in_pl[4][33:2];
  assign m_rresp   = in_pl[4][1:0];
  assign m_rvalid  = in_v[4];
  assign s_rready  = out_r[4];
  assign out_pl[4] = {30'b0, s_rdata, s_rresp};
  assign out_v[4]  = s_rvalid;
  assign in_r[4]   = m_rready;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ch_mask(input int c);
    int w;
    case (c)
      1:       w = 36;
      2:       w = 2;
      4:       w = 34;
      default: w = 32;
    endcase
    return (64'd1 << w) - 64'd1;
  endfunction

  // Reference model: per-channel FIFO of accepted beats, capacity two
  logic [63:0] mq [5][$];
  logic        rst_seen = 1'b0;

  // Compare on the falling edge, then advance the model for the coming rising edge
  always begin
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      logic exp_ir, exp_ov;
      exp_ir = rst_seen && (mq[c].size() < 2);
      exp_ov = (mq[c].size() > 0);
      chk($sformatf("ch%0d in_ready", c), 64'(in_r[c]), 64'(exp_ir));
      chk($sformatf("ch%0d out_valid", c), 64'(out_v[c]), 64'(exp_ov));
      if (exp_ov) chk($sformatf("ch%0d payload", c), out_pl[c], mq[c][0]);
      in_hs[c] = 1'b0;
      if (!rst_n) begin
        mq[c].delete();
      end else begin
        if (exp_ov && out_r[c]) void'(mq[c].pop_front());
        if (exp_ir && in_v[c]) begin
          mq[c].push_back(in_pl[c] & ch_mask(c));
          in_hs[c] = 1'b1;
        end
      end
    end
    rst_seen = rst_n;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int rdy_pct;
    rst_n = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_v[c]  = 1'b0;
      in_pl[c] = '0;
      out_r[c] = 1'b0;
      in_hs[c] = 1'b0;
    end

    // Reset for three cycles
    repeat (3) step();
    chk("rst s_awready", 64'(s_awready), 64'd0);
    chk("rst m_bready", 64'(m_bready), 64'd0);
    chk("rst m_wvalid", 64'(m_wvalid), 64'd0);
    chk("rst m_awaddr", 64'(m_awaddr), 64'd0);
    chk("rst s_rdata", 64'(s_rdata), 64'd0);
    rst_n = 1'b1;
    step();
    chk("post-rst s_awready", 64'(s_awready), 64'd1);
    chk("post-rst s_wready", 64'(s_wready), 64'd1);
    chk("post-rst s_arready", 64'(s_arready), 64'd1);
    chk("post-rst m_bready", 64'(m_bready), 64'd1);
    chk("post-rst m_rready", 64'(m_rready), 64'd1);

    // Single write plus its response
    for (int c = 0; c < 5; c++) out_r[c] = 1'b1;
    in_v[0] = 1'b1; in_pl[0] = 64'h1000_0004;
    in_v[1] = 1'b1; in_pl[1] = {28'b0, 32'hDEAD_BEEF, 4'hF};
    step();
    in_v[0] = 1'b0; in_v[1] = 1'b0;
    chk("wr m_awvalid", 64'(m_awvalid), 64'd1);
    chk("wr m_awaddr", 64'(m_awaddr), 64'h1000_0004);
    chk("wr m_wdata", 64'(m_wdata), 64'hDEAD_BEEF);
    chk("wr m_wstrb", 64'(m_wstrb), 64'hF);
    in_v[2] = 1'b1; in_pl[2] = 64'd0;
    step();
    in_v[2] = 1'b0;
    chk("wr s_bvalid", 64'(s_bvalid), 64'd1);
    chk("wr s_bresp", 64'(s_bresp), 64'd0);
    step();
    chk("wr s_bvalid drop", 64'(s_bvalid), 64'd0);

    // Streaming reads, one per cycle
    for (int i = 0; i < 8; i++) begin
      in_v[3] = 1'b1; in_pl[3] = 64'(i * 4);
      step();
      chk("stream m_araddr", 64'(m_araddr), 64'(i * 4));
      chk("stream s_arready", 64'(s_arready), 64'd1);
    end
    in_v[3] = 1'b0;
    step();

    // AR backpressure: A0 main, A4 skid, A8 held at input
    out_r[3] = 1'b0;
    in_v[3] = 1'b1; in_pl[3] = 64'hA0;
    step();
    in_pl[3] = 64'hA4;
    step();
    in_pl[3] = 64'hA8;
    step();
    chk("bp s_arready", 64'(s_arready), 64'd0);
    chk("bp m_araddr", 64'(m_araddr), 64'hA0);
    out_r[3] = 1'b1;
    step();
    chk("bp release A4", 64'(m_araddr), 64'hA4);
    step();
    in_v[3] = 1'b0;
    chk("bp release A8", 64'(m_araddr), 64'hA8);
    chk("bp A8 valid", 64'(m_arvalid), 64'd1);
    step();

    // R backpressure with non-OKAY responses
    out_r[4] = 1'b0;
    in_v[4] = 1'b1; in_pl[4] = {30'b0, 32'h11, 2'b10};
    step();
    in_pl[4] = {30'b0, 32'h22, 2'b11};
    step();
    in_v[4] = 1'b0;
    chk("rbp m_rready", 64'(m_rready), 64'd0);
    chk("rbp s_rdata 1st", 64'(s_rdata), 64'h11);
    out_r[4] = 1'b1;
    step();
    chk("rbp s_rdata 2nd", 64'(s_rdata), 64'h22);
    chk("rbp s_rresp 2nd", 64'(s_rresp), 64'd3);
    step();
    chk("rbp drained", 64'(s_rvalid), 64'd0);

    // Fill AW and W skids, then reset mid-transaction
    out_r[0] = 1'b0; out_r[1] = 1'b0;
    in_v[0] = 1'b1; in_v[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_pl[0] = 64'h5000 + 64'(i);
      in_pl[1] = 64'h7000 + 64'(i);
      step();
    end
    chk("mid s_awready", 64'(s_awready), 64'd0);
    rst_n = 1'b0; in_v[0] = 1'b0; in_v[1] = 1'b0;
    step();
    rst_n = 1'b1; out_r[0] = 1'b1; out_r[1] = 1'b1;
    chk("mid m_awvalid", 64'(m_awvalid), 64'd0);
    chk("mid m_awaddr", 64'(m_awaddr), 64'd0);
    repeat (3) step();
    chk("mid m_wvalid later", 64'(m_wvalid), 64'd0);

    // Randomized traffic on all channels; valid held until accepted
    for (int ph = 0; ph < 4; ph++) begin
      rdy_pct = 20 + ph * 25;
      repeat (800) begin
        for (int c = 0; c < 5; c++) begin
          if (!in_v[c] || in_hs[c]) begin
            in_v[c]  = ($urandom_range(0, 99) < 70);
            in_pl[c] = {$urandom, $urandom} & ch_mask(c);
          end
          out_r[c] = ($urandom_range(0, 99) < rdy_pct);
        end
        step();
      end
    end
    for (int c = 0; c < 5; c++) begin
      in_v[c]  = 1'b0;
      out_r[c] = 1'b1;
    end
    repeat (5) step();
    for (int c = 0; c < 5; c++) chk($sformatf("ch%0d drained", c), 64'(out_v[c]), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
